// File: rtl/bit_ser_pkg.sv
// bit_ser_pkg: shared state type, default sizes and parity helper for bit_serializer
package bit_ser_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, PARITY, GAP} bit_ser_state_t;

    localparam int BIT_SER_WIDTH      = 8;
    localparam int BIT_SER_GAP_CYCLES = 1;

    // Even parity over a zero-extended word; valid for words up to 64 bits.
    function automatic logic even_parity(input logic [63:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/bit_ser_holdbuf.sv
// bit_ser_holdbuf: one-entry word buffer with load/drain and full flag
import bit_ser_pkg::*;

module bit_ser_holdbuf #(
    parameter int WIDTH = BIT_SER_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             drain,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full
);

    // Capture on load; a simultaneous drain and load leaves the buffer full with the new word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full <= 1'b0;
            dout <= '0;
        end else begin
            if (load) dout <= din;
            full <= load || (full && !drain);
        end
    end

endmodule

// File: rtl/bit_serializer.sv
// bit_serializer: MSB-first parallel-to-serial stage with zero-bit frame gaps; BIT_SER_PARITY_EN adds an even-parity bit
import bit_ser_pkg::*;

module bit_serializer #(
    parameter int WIDTH      = BIT_SER_WIDTH,
    parameter int GAP_CYCLES = BIT_SER_GAP_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             ser_out,
    output logic             ser_active,
    output logic             frame_done
);

    localparam int CW = $clog2(WIDTH);
    localparam int GW = GAP_CYCLES > 0 ? $clog2(GAP_CYCLES + 1) : 1;

    bit_ser_state_t   state, state_d;
    logic [WIDTH-1:0] shreg, shreg_d, buf_data;
    logic [CW-1:0]    bitcnt, bitcnt_d;
    logic [GW-1:0]    gap_cnt, gap_cnt_d;
    logic             buf_full, accept, load_pt, load;
    logic             ser_out_d, ser_active_d, frame_done_d;
`ifdef BIT_SER_PARITY_EN
    logic             par, par_d;
`endif

    assign in_ready = rst_n && !buf_full;
    assign accept   = in_valid && in_ready;

    bit_ser_holdbuf #(.WIDTH(WIDTH)) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept && !load_pt),
        .drain (load_pt && buf_full),
        .din   (in_data),
        .dout  (buf_data),
        .full  (buf_full)
    );

    // Next-state: load_pt marks cycles where a new frame may start next; the buffer wins over bypass.
    always_comb begin
        state_d   = state;
        shreg_d   = shreg;
        bitcnt_d  = bitcnt;
        gap_cnt_d = gap_cnt;
        load_pt   = 1'b0;
`ifdef BIT_SER_PARITY_EN
        par_d     = par;
`endif
        case (state)
            IDLE: load_pt = 1'b1;
            SHIFT: begin
                if (bitcnt != '0) begin
                    shreg_d  = shreg << 1;
                    bitcnt_d = bitcnt - 1'b1;
                end else begin
`ifdef BIT_SER_PARITY_EN
                    state_d = PARITY;
`else
                    if (GAP_CYCLES == 0) load_pt = 1'b1;
                    else begin
                        state_d   = GAP;
                        gap_cnt_d = GW'(GAP_CYCLES);
                    end
`endif
                end
            end
`ifdef BIT_SER_PARITY_EN
            PARITY: begin
                if (GAP_CYCLES == 0) load_pt = 1'b1;
                else begin
                    state_d   = GAP;
                    gap_cnt_d = GW'(GAP_CYCLES);
                end
            end
`endif
            GAP: begin
                gap_cnt_d = gap_cnt - 1'b1;
                load_pt   = gap_cnt == GW'(1);
            end
            default: state_d = IDLE;
        endcase
        load = load_pt && (buf_full || accept);
        if (load_pt) state_d = load ? SHIFT : IDLE;
        if (load) begin
            shreg_d  = buf_full ? buf_data : in_data;
            bitcnt_d = CW'(WIDTH - 1);
`ifdef BIT_SER_PARITY_EN
            par_d    = even_parity(64'(shreg_d));
`endif
        end
`ifdef BIT_SER_PARITY_EN
        ser_out_d    = state_d == SHIFT ? shreg_d[WIDTH-1] : (state_d == PARITY && par_d);
        frame_done_d = state_d == PARITY;
`else
        ser_out_d    = state_d == SHIFT && shreg_d[WIDTH-1];
        frame_done_d = state_d == SHIFT && bitcnt_d == '0;
`endif
        ser_active_d = state_d == SHIFT || state_d == PARITY;
    end

    // State, datapath and registered serial outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            shreg      <= '0;
            bitcnt     <= '0;
            gap_cnt    <= '0;
            ser_out    <= 1'b0;
            ser_active <= 1'b0;
            frame_done <= 1'b0;
`ifdef BIT_SER_PARITY_EN
            par        <= 1'b0;
`endif
        end else begin
            state      <= state_d;
            shreg      <= shreg_d;
            bitcnt     <= bitcnt_d;
            gap_cnt    <= gap_cnt_d;
            ser_out    <= ser_out_d;
            ser_active <= ser_active_d;
            frame_done <= frame_done_d;
`ifdef BIT_SER_PARITY_EN
            par        <= par_d;
`endif
        end
    end

endmodule
